// File: rtl/lsu_mem_ctrl_if.sv
// Port bundle for lsu_mem_ctrl: upstream op, downstream result and data-memory bus.
// The master modport is the LSU view; the slave modport is the surrounding pipeline/memory.
interface lsu_mem_ctrl_if #(
  parameter int unsigned CPU_WIDTH = 64
);
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_mem_en;
  logic                 i_store;
  logic                 i_unsigned;
  logic [1:0]           i_size;
  logic [CPU_WIDTH-1:0] i_addr;
  logic [CPU_WIDTH-1:0] i_wdata;
  logic                 o_valid;
  logic                 i_ready;
  logic [CPU_WIDTH-1:0] o_lsu_res;
  logic                 o_load_en;
  logic                 o_misalign;
  logic                 o_mem_req;
  logic                 i_mem_gnt;
  logic                 o_mem_we;
  logic [CPU_WIDTH-1:0] o_mem_addr;
  logic [CPU_WIDTH-1:0] o_mem_wdata;
  logic [7:0]           o_mem_wstrb;
  logic                 i_mem_rvalid;
  logic [CPU_WIDTH-1:0] i_mem_rdata;

  modport master (
    input  i_valid, i_mem_en, i_store, i_unsigned, i_size, i_addr, i_wdata,
    input  i_ready, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_ready, o_valid, o_lsu_res, o_load_en, o_misalign,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
  );

  modport slave (
    output i_valid, i_mem_en, i_store, i_unsigned, i_size, i_addr, i_wdata,
    output i_ready, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_valid, o_lsu_res, o_load_en, o_misalign,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit stage: one memory op per transaction over a req/gnt + rvalid bus,
// with load alignment/extension and store lane shifting/strobes.
module lsu_mem_ctrl #(
  parameter int unsigned CPU_WIDTH = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  lsu_mem_ctrl_if.master lsu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_valid;
  logic                 r_store;
  logic                 r_unsigned;
  logic [1:0]           r_size;
  logic [2:0]           r_lane;
  logic [CPU_WIDTH-1:0] r_lsu_res;
  logic                 r_load_en;
  logic                 r_misalign;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [CPU_WIDTH-1:0] r_mem_addr;
  logic [CPU_WIDTH-1:0] r_mem_wdata;
  logic [7:0]           r_mem_wstrb;

  logic                 w_misalign;
  logic [7:0]           w_strb_base;
  logic [7:0]           w_strb;
  logic [CPU_WIDTH-1:0] w_shifted;
  logic [CPU_WIDTH-1:0] w_ext;

  always_comb begin
    w_misalign  = 1'b0;
    w_strb_base = 8'h00;
    case (lsu.i_size)
      2'b00: begin w_misalign = 1'b0;              w_strb_base = 8'h01; end
      2'b01: begin w_misalign = lsu.i_addr[0];     w_strb_base = 8'h03; end
      2'b10: begin w_misalign = |lsu.i_addr[1:0];  w_strb_base = 8'h0F; end
      default: begin w_misalign = |lsu.i_addr[2:0]; w_strb_base = 8'hFF; end
    endcase
    w_strb = w_strb_base << lsu.i_addr[2:0];
  end

  // Read data arrives 8-byte aligned; bring the addressed lane down to bit 0 first.
  assign w_shifted = lsu.i_mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_ext = '0;
    case (r_size)
      2'b00: w_ext = r_unsigned ? {{(CPU_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                : {{(CPU_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      2'b01: w_ext = r_unsigned ? {{(CPU_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                : {{(CPU_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      2'b10: w_ext = r_unsigned ? {{(CPU_WIDTH-32){1'b0}}, w_shifted[31:0]}
                                : {{(CPU_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_store     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 3'b000;
      r_lsu_res   <= '0;
      r_load_en   <= 1'b0;
      r_misalign  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.i_valid) begin
            r_ready    <= 1'b0;
            r_store    <= lsu.i_store;
            r_unsigned <= lsu.i_unsigned;
            r_size     <= lsu.i_size;
            r_lane     <= lsu.i_addr[2:0];
            r_lsu_res  <= '0;
            r_load_en  <= 1'b0;
            if (!lsu.i_mem_en || w_misalign) begin
              // Misalignment only matters for ops that would touch memory.
              r_misalign <= lsu.i_mem_en & w_misalign;
              r_valid    <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_misalign  <= 1'b0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= lsu.i_store;
              r_mem_addr  <= {lsu.i_addr[CPU_WIDTH-1:3], 3'b000};
              r_mem_wdata <= lsu.i_wdata << {lsu.i_addr[2:0], 3'b000};
              r_mem_wstrb <= lsu.i_store ? w_strb : 8'h00;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (lsu.i_mem_gnt) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 8'h00;
            if (r_store) begin
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (lsu.i_mem_rvalid) begin
            r_lsu_res <= w_ext;
            r_load_en <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (lsu.i_ready) begin
            r_valid    <= 1'b0;
            r_load_en  <= 1'b0;
            r_misalign <= 1'b0;
            r_lsu_res  <= '0;
            r_ready    <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lsu.o_ready     = r_ready;
  assign lsu.o_valid     = r_valid;
  assign lsu.o_lsu_res   = r_lsu_res;
  assign lsu.o_load_en   = r_load_en;
  assign lsu.o_misalign  = r_misalign;
  assign lsu.o_mem_req   = r_mem_req;
  assign lsu.o_mem_we    = r_mem_we;
  assign lsu.o_mem_addr  = r_mem_addr;
  assign lsu.o_mem_wdata = r_mem_wdata;
  assign lsu.o_mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: drives ops, models the memory bus per cycle,
// and checks results against a scoreboard of expected values.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [63:0] res;
    logic        load_en;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  lsu_mem_ctrl_if #(.CPU_WIDTH(64)) u_if ();

  lsu_mem_ctrl #(.CPU_WIDTH(64)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .lsu     (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic en, input logic st, input logic uns,
                        input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, input int unsigned gdel,
                        input logic [63:0] eres, input logic eld, input logic emis,
                        input int unsigned elat, input logic [63:0] ewdata,
                        input logic [7:0] estrb, input int unsigned stall);
    exp_t e;
    exp_t got;
    int unsigned lat = 0;
    int unsigned nreq = 0;
    bit done = 0;
    e.res = eres; e.load_en = eld; e.mis = emis;
    sb.push_back(e);
    @(negedge clk);
    u_if.i_valid = 1'b1; u_if.i_mem_en = en; u_if.i_store = st; u_if.i_unsigned = uns;
    u_if.i_size = sz; u_if.i_addr = addr; u_if.i_wdata = wd; u_if.i_ready = 1'b0;
    @(posedge clk);
    #1 u_if.i_valid = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      u_if.i_mem_gnt = 1'b0; u_if.i_mem_rvalid = 1'b0; u_if.i_mem_rdata = '0;
      if (u_if.o_mem_req) begin
        chk({tag, ".addr"}, u_if.o_mem_addr, {addr[63:3], 3'b000});
        chk({tag, ".we"}, u_if.o_mem_we, st);
        chk({tag, ".wstrb"}, u_if.o_mem_wstrb, estrb);
        if (st) chk({tag, ".wdata"}, u_if.o_mem_wdata, ewdata);
        if (nreq == gdel) u_if.i_mem_gnt = 1'b1;
        nreq++;
      end else if (u_if.o_valid) begin
        done = 1;
      end else if (en && !st && nreq > 0) begin
        u_if.i_mem_rvalid = 1'b1;
        u_if.i_mem_rdata = rd;
      end
    end
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".nreq"}, nreq, (en && !emis) ? gdel + 1 : 0);
    if (done) begin
      got = sb.pop_front();
      chk({tag, ".res"}, u_if.o_lsu_res, got.res);
      chk({tag, ".load_en"}, u_if.o_load_en, got.load_en);
      chk({tag, ".misalign"}, u_if.o_misalign, got.mis);
      chk({tag, ".ready_busy"}, u_if.o_ready, 1'b0);
      for (int i = 0; i < int'(stall); i++) begin
        u_if.i_valid = 1'b1; u_if.i_mem_en = 1'b1; u_if.i_store = 1'b1;
        u_if.i_size = 2'b11; u_if.i_addr = 64'h100;
        @(negedge clk);
        chk({tag, ".stall_valid"}, u_if.o_valid, 1'b1);
        chk({tag, ".stall_ready"}, u_if.o_ready, 1'b0);
        chk({tag, ".stall_res"}, u_if.o_lsu_res, got.res);
        chk({tag, ".stall_req"}, u_if.o_mem_req, 1'b0);
      end
    end
    u_if.i_valid = 1'b0;
    u_if.i_ready = 1'b1;
    @(negedge clk);
    u_if.i_ready = 1'b0;
    chk({tag, ".post_valid"}, u_if.o_valid, 1'b0);
    chk({tag, ".post_ready"}, u_if.o_ready, 1'b1);
    chk({tag, ".post_req"}, u_if.o_mem_req, 1'b0);
  endtask

  initial begin
    u_if.i_valid = 1'b0; u_if.i_mem_en = 1'b0; u_if.i_store = 1'b0; u_if.i_unsigned = 1'b0;
    u_if.i_size = 2'b00; u_if.i_addr = '0; u_if.i_wdata = '0; u_if.i_ready = 1'b0;
    u_if.i_mem_gnt = 1'b0; u_if.i_mem_rvalid = 1'b0; u_if.i_mem_rdata = '0;

    #2;
    chk("rst.valid", u_if.o_valid, 1'b0);
    chk("rst.req", u_if.o_mem_req, 1'b0);
    chk("rst.we", u_if.o_mem_we, 1'b0);
    chk("rst.mis", u_if.o_misalign, 1'b0);
    chk("rst.load_en", u_if.o_load_en, 1'b0);
    chk("rst.res", u_if.o_lsu_res, 64'h0);
    chk("rst.addr", u_if.o_mem_addr, 64'h0);
    chk("rst.wdata", u_if.o_mem_wdata, 64'h0);
    chk("rst.wstrb", u_if.o_mem_wstrb, 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", u_if.o_ready, 1'b1);

    run_op("lb3",  1, 0, 0, 2'b00, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 0,
           64'hFFFF_FFFF_FFFF_FF80, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("lb2",  1, 0, 0, 2'b00, 64'h80000002, 64'h0, 64'h00000000_80FF0000, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("lhu",  1, 0, 1, 2'b01, 64'h10000006, 64'h0, 64'hBEEF0000_00000000, 0,
           64'h0000_0000_0000_BEEF, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("lh",   1, 0, 0, 2'b01, 64'h10000006, 64'h0, 64'hBEEF0000_00000000, 0,
           64'hFFFF_FFFF_FFFF_BEEF, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("sw",   1, 1, 0, 2'b10, 64'h20000004, 64'h12345678, 64'h0, 3,
           64'h0, 0, 0, 5, 64'h12345678_00000000, 8'hF0, 0);
    run_op("lw_mis", 1, 0, 0, 2'b10, 64'h1002, 64'h0, 64'h0, 0,
           64'h0, 0, 1, 1, 64'h0, 8'h00, 0);
    run_op("pass", 0, 0, 0, 2'b11, 64'h1238, 64'h5555, 64'h0, 0,
           64'h0, 0, 0, 1, 64'h0, 8'h00, 5);
    run_op("ld_u", 1, 0, 1, 2'b11, 64'h8, 64'h0, 64'h80000000_00000001, 2,
           64'h80000000_00000001, 1, 0, 5, 64'h0, 8'h00, 2);
    run_op("lw",   1, 0, 0, 2'b10, 64'h4, 64'h0, 64'h80000000_00000000, 0,
           64'hFFFF_FFFF_8000_0000, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("lwu",  1, 0, 1, 2'b10, 64'h4, 64'h0, 64'h80000000_00000000, 0,
           64'h0000_0000_8000_0000, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("lbu7", 1, 0, 1, 2'b00, 64'h7, 64'h0, 64'h9A000000_00000000, 0,
           64'h9A, 1, 0, 3, 64'h0, 8'h00, 0);
    run_op("sb5",  1, 1, 0, 2'b00, 64'h5, 64'hAB, 64'h0, 1,
           64'h0, 0, 0, 3, 64'h0000AB00_00000000, 8'h20, 0);
    run_op("sh2",  1, 1, 0, 2'b01, 64'h32, 64'hCAFE, 64'h0, 0,
           64'h0, 0, 0, 2, 64'h00000000_CAFE0000, 8'h0C, 0);
    run_op("sd",   1, 1, 0, 2'b11, 64'h40, 64'h01234567_89ABCDEF, 64'h0, 0,
           64'h0, 0, 0, 2, 64'h01234567_89ABCDEF, 8'hFF, 0);
    run_op("ld_mis", 1, 0, 0, 2'b11, 64'h104, 64'h0, 64'h0, 0,
           64'h0, 0, 1, 1, 64'h0, 8'h00, 0);
    run_op("lh_mis", 1, 0, 0, 2'b01, 64'h1, 64'h0, 64'h0, 0,
           64'h0, 0, 1, 1, 64'h0, 8'h00, 0);

    // Reset while a load sits in WAIT, then a stray rvalid/gnt after release.
    @(negedge clk);
    u_if.i_valid = 1'b1; u_if.i_mem_en = 1'b1; u_if.i_store = 1'b0; u_if.i_unsigned = 1'b0;
    u_if.i_size = 2'b11; u_if.i_addr = 64'h200;
    @(posedge clk);
    #1 u_if.i_valid = 1'b0;
    @(negedge clk);
    chk("rstw.req", u_if.o_mem_req, 1'b1);
    u_if.i_mem_gnt = 1'b1;
    @(negedge clk);
    u_if.i_mem_gnt = 1'b0;
    chk("rstw.wait_req", u_if.o_mem_req, 1'b0);
    chk("rstw.wait_valid", u_if.o_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstw.valid", u_if.o_valid, 1'b0);
    chk("rstw.req0", u_if.o_mem_req, 1'b0);
    chk("rstw.addr", u_if.o_mem_addr, 64'h0);
    chk("rstw.res", u_if.o_lsu_res, 64'h0);
    chk("rstw.load_en", u_if.o_load_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    u_if.i_mem_rvalid = 1'b1; u_if.i_mem_gnt = 1'b1; u_if.i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    u_if.i_mem_rvalid = 1'b0; u_if.i_mem_gnt = 1'b0; u_if.i_mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw.idle_valid", u_if.o_valid, 1'b0);
      chk("rstw.idle_ready", u_if.o_ready, 1'b1);
      chk("rstw.idle_load_en", u_if.o_load_en, 1'b0);
      chk("rstw.idle_req", u_if.o_mem_req, 1'b0);
      @(negedge clk);
    end

    chk("sb.empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
